dc_handshake_tx: RTL and testbench
==================================

# dc_handshake_tx

Source-domain end of a two-phase (toggle) request/acknowledge clock-domain crossing. The block captures a word from a local valid/ready stream and holds it stable on a crossing bus. It then toggles a request line and waits for the destination's acknowledge toggle, which it brings in through an internal multi-stage synchronizer, before it accepts the next word. It sits in the sending clock domain of the axi_slice_dc family, opposite the destination-side synchronizer/receiver.

## Interface
- WIDTH, 32: data word width.
- SYNC_STAGES, 2: flops in the tx_ack synchronizer; legal range 2..4.
- RESET_VALUE, 'h0: reset value of tx_data.
- STALL_LIMIT, 1024: WAIT_ACK cycles before stall_err is set; 0 disables the check.
- clk  input  1  source-domain clock; all flops are rising-edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  local word available.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  local word.
- tx_req  output  1  request toggle to the destination domain, registered.
- tx_data  output  WIDTH  crossing data, registered; stable while a transfer is pending.
- tx_ack  input  1  acknowledge toggle from the destination domain; asynchronous to clk.
- done  output  1  one-cycle pulse when a transfer completes.
- busy  output  1  transfer outstanding.
- stall_err  output  1  sticky: the acknowledge wait exceeded STALL_LIMIT.
- err_clr  input  1  clears stall_err.

## Operation
- FSM with two states, IDLE and WAIT_ACK. Reset enters IDLE.
- Asynchronous reset forces: tx_req=0, tx_data=RESET_VALUE, all sync flops=0, stall counter=0, stall_err=0, done=0, state=IDLE.
- in_ready = (state==IDLE), combinational from state. busy = (state==WAIT_ACK).
- IDLE, in_valid&&in_ready at an edge:
  - tx_data <= in_data;
  - tx_req <= ~tx_req;
  - stall counter <= 0;
  - state <= WAIT_ACK.
- IDLE, no in_valid: all registers hold.
- ack_s = output of the SYNC_STAGES-deep flop chain on tx_ack. No other logic samples tx_ack.
- WAIT_ACK, ack_s==tx_req at an edge: state <= IDLE and done <= 1 for exactly one cycle.
- WAIT_ACK, ack_s!=tx_req at an edge: the stall counter increments, saturating at STALL_LIMIT. When it reaches STALL_LIMIT (STALL_LIMIT≠0), stall_err <= 1.
- Timeout is report-only. The transfer is never abandoned, and tx_req/tx_data are never changed, until the acknowledge arrives.
- stall_err clears on err_clr. If a set condition occurs in the same cycle as err_clr, set wins.
- in_data and in_valid are ignored in WAIT_ACK. tx_data changes only on an accept edge.
- An ack_s toggle seen in IDLE is a protocol violation. It is ignored; the FSM does not change state.
- Reset mid-transfer aborts the word. The destination must be reset in the same reset window so that its acknowledge returns to 0.

## Timing
- The accept at edge E0 makes tx_req and tx_data change after E0. tx_data is valid no later than tx_req (same edge).
- With tx_ack tied to tx_req (zero-latency loopback), ack_s matches tx_req after edge E0+SYNC_STAGES.
- The FSM returns to IDLE at E0+SYNC_STAGES+1. done is high during the following cycle.
- in_ready rises after E0+SYNC_STAGES+1, so the next accept can occur at that edge + 1 cycle.
- Minimum period under loopback: SYNC_STAGES+2 clk cycles per word.
- Real destination latency adds directly to this period.
- stall_err rises STALL_LIMIT WAIT_ACK edges after the accept if no acknowledge arrives.
- The counter width is clog2(STALL_LIMIT+1).

## Test plan
- Reset: assert rst asynchronously between edges. Required: all outputs take their reset values immediately (tx_req=0, tx_data=RESET_VALUE, in_ready=1, busy=0, done=0, stall_err=0).
- Loopback, SYNC_STAGES=2, tx_ack tied to tx_req, in_valid held high with data 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003. Required: three tx_req toggles spaced 4 cycles apart, three done pulses, and tx_data stable between toggles.
- Destination model acknowledging after 10 cycles. Required: in_ready stays 0 for the whole wait; in_data changes during WAIT_ACK do not alter tx_data.
- STALL_LIMIT=8 with tx_ack held. Required: stall_err=1 eight WAIT_ACK edges after the accept, and it persists. A late acknowledge still completes with done=1. err_clr then drops stall_err.
- Reset in WAIT_ACK after tx_req=1, destination also reset. Required: tx_req=0 and IDLE; the next word completes normally.
- Spurious tx_ack toggle while IDLE. Required: no done pulse, no state change, and no tx_req change.

Source files
------------

// File: rtl/dc_handshake_tx.sv
// Source-domain end of a two-phase request/acknowledge crossing: capture a word,
// toggle tx_req, and hold tx_data until the synchronized acknowledge matches.
module dc_handshake_tx #(
  parameter int                WIDTH       = 32,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int                STALL_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             tx_req,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ack,
  output logic             done,
  output logic             busy,
  output logic             stall_err,
  input  logic             err_clr
);

  localparam int CNT_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   tx_req_reg;
  logic [WIDTH-1:0]       tx_data_reg;
  logic                   done_reg;
  logic                   stall_err_reg;
  logic [CNT_W-1:0]       cnt_reg;

  logic ack_s;
  logic ack_match;
  logic accept;
  logic stall_step;
  logic stall_set;

  // tx_ack is asynchronous; only the last flop of this chain is ever used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], tx_ack};
    end
  end

  assign ack_s     = sync_reg[SYNC_STAGES-1];
  assign ack_match = (ack_s == tx_req_reg);
  assign accept    = (state_reg == IDLE) && in_valid;

  // The counter stops at the limit, so the error is raised once per stalled transfer.
  assign stall_step = (STALL_LIMIT != 0) && (state_reg == WAIT_ACK) && !ack_match
                      && (cnt_reg != LIMIT);
  assign stall_set  = stall_step && (cnt_reg == (LIMIT - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (in_valid) state_next = WAIT_ACK;
      WAIT_ACK: if (ack_match) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == IDLE);
    busy     = (state_reg == WAIT_ACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_req_reg    <= 1'b0;
      tx_data_reg   <= RESET_VALUE;
      done_reg      <= 1'b0;
      stall_err_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      done_reg <= (state_reg == WAIT_ACK) && ack_match;
      if (accept) begin
        tx_data_reg <= in_data;
        tx_req_reg  <= ~tx_req_reg;
        cnt_reg     <= '0;
      end else if (stall_step) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (stall_set) begin
        stall_err_reg <= 1'b1;
      end else if (err_clr) begin
        stall_err_reg <= 1'b0;
      end
    end
  end

  assign tx_req    = tx_req_reg;
  assign tx_data   = tx_data_reg;
  assign done      = done_reg;
  assign stall_err = stall_err_reg;

endmodule

// File: tb/tb_dc_handshake_tx.sv
// Self-checking bench for dc_handshake_tx: loopback vector table, directed corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_dc_handshake_tx;

  localparam int          W  = 32;
  localparam int          S  = 2;
  localparam int          L  = 8;
  localparam logic [31:0] RV = 32'h1234_5678;

  logic          clk;
  logic          rst;
  logic          iv;
  logic [W-1:0]  id;
  logic          clr;
  logic          loop;
  logic          ack_drv;
  logic          in_ready, tx_req, done, busy, stall_err;
  logic [W-1:0]  tx_data;
  logic          tx_ack;

  assign tx_ack = loop ? tx_req : ack_drv;

  dc_handshake_tx #(
    .WIDTH(W), .SYNC_STAGES(S), .RESET_VALUE(RV), .STALL_LIMIT(L)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(in_ready), .in_data(id),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack), .done(done),
    .busy(busy), .stall_err(stall_err), .err_clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: transaction state plus a queue delaying tx_ack by S samples.
  logic         m_busy, m_req, m_done, m_err;
  logic [W-1:0] m_data;
  int           m_wait;
  bit           ack_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_req = 0; m_done = 0; m_err = 0; m_data = RV; m_wait = 0;
    ack_q = {};
    repeat (S) ack_q.push_back(1'b0);
  endtask

  task automatic step();
    logic a, s, dn, st;
    a = loop ? m_req : ack_drv;
    @(posedge clk);
    #1;
    cyc++;
    s = ack_q.pop_front();
    ack_q.push_back(a);
    dn = 0; st = 0;
    if (!m_busy) begin
      if (iv) begin
        m_data = id; m_req = ~m_req; m_wait = 0; m_busy = 1;
      end
    end else if (s == m_req) begin
      m_busy = 0; dn = 1;
    end else if (m_wait < L) begin
      m_wait++;
      if (m_wait == L) st = 1;
    end
    m_done = dn;
    if (st) m_err = 1;
    else if (clr) m_err = 0;
    chk("cycle", {27'b0, in_ready, busy, tx_req, done, stall_err, tx_data},
                 {27'b0, ~m_busy, m_busy, m_req, m_done, m_err, m_data});
    $display("cyc %0d: iv=%b id=%h ack=%b clr=%b -> rdy=%b req=%b data=%h done=%b err=%b",
             cyc, iv, id, a, clr, in_ready, tx_req, tx_data, done, stall_err);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    iv = 0; clr = 0; ack_drv = 0;
    rst = 1;
    #1;
    chk("rst_outputs", {27'b0, in_ready, busy, tx_req, done, stall_err, tx_data},
                       {27'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RV});
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      if (done) seen = 1;
    end
    chk(name, {63'b0, seen}, 64'd1);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic [31:0] exp_data;
    logic        exp_req;
    logic        exp_ready;
    logic        exp_done;
  } vec_t;

  vec_t tbl[13];

  localparam logic [31:0] A1 = 32'hA5A5_0001;
  localparam logic [31:0] A2 = 32'hA5A5_0002;
  localparam logic [31:0] A3 = 32'hA5A5_0003;
  localparam logic [31:0] FX = 32'hFFFF_FFFF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         req0;
    logic [W-1:0] word;
    rst = 0; iv = 0; id = '0; clr = 0; loop = 0; ack_drv = 0;
    model_reset();

    async_reset();

    // Loopback: three words back to back, tx_req toggles every S+2 cycles.
    tbl[0]  = '{1'b1, A1, A1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, A2, A1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, A2, A1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, A2, A1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, A2, A2, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, A3, A2, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, A3, A2, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, A3, A2, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, A3, A3, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, FX, A3, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, FX, A3, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, FX, A3, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, FX, A3, 1'b1, 1'b1, 1'b0};
    loop = 1;
    for (int i = 0; i < 13; i++) begin
      iv = tbl[i].iv; id = tbl[i].id;
      step();
      chk("tbl_loopback", {29'b0, in_ready, done, tx_req, tx_data},
                          {29'b0, tbl[i].exp_ready, tbl[i].exp_done, tbl[i].exp_req, tbl[i].exp_data});
    end
    ack_drv = m_req;
    loop = 0;
    iv = 0;

    // Spurious acknowledge toggle while idle.
    req0 = m_req;
    ack_drv = ~m_req;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("spurious_idle", {61'b0, done, in_ready, tx_req}, {61'b0, 1'b0, 1'b1, req0});
    end
    ack_drv = m_req;
    repeat (S + 1) step();

    // Stall limit: no acknowledge for L edges, then a late acknowledge.
    iv = 1; id = 32'hC0DE_0001;
    step();
    iv = 0;
    for (int k = 1; k <= L; k++) begin
      step();
      chk("stall_err_rise", {63'b0, stall_err}, {63'b0, (k == L)});
    end
    repeat (3) begin
      step();
      chk("stall_err_sticky", {62'b0, stall_err, busy}, {62'b0, 2'b11});
    end
    ack_drv = m_req;
    wait_done("late_ack_done");
    chk("stall_err_after_done", {63'b0, stall_err}, 64'd1);
    clr = 1;
    step();
    clr = 0;
    chk("stall_err_cleared", {63'b0, stall_err}, 64'd0);

    // Destination acknowledging after 10 cycles; in_data churns during the wait.
    word = 32'h0BAD_F00D;
    iv = 1; id = word;
    step();
    for (int i = 0; i < 10; i++) begin
      id = $urandom;
      step();
      chk("wait_ready_low", {31'b0, in_ready, tx_data}, {31'b0, 1'b0, word});
    end
    iv = 0;
    ack_drv = m_req;
    wait_done("dest10_done");
    clr = 1;
    step();
    clr = 0;

    // Reset in the middle of a transfer, destination reset alongside.
    async_reset();
    iv = 1; id = 32'h5555_AAAA;
    step();
    iv = 0;
    step();
    chk("mid_xfer_pending", {62'b0, tx_req, busy}, {62'b0, 2'b11});
    async_reset();
    loop = 1;
    iv = 1; id = 32'h7777_0001;
    step();
    iv = 0;
    wait_done("post_reset_done");
    chk("post_reset_data", {32'b0, tx_data}, {32'b0, 32'h7777_0001});
    ack_drv = m_req;
    loop = 0;

    // Randomized traffic with a lazy destination and occasional stray toggles.
    for (int i = 0; i < 600; i++) begin
      int r;
      iv  = ($urandom_range(0, 99) < 60);
      id  = $urandom;
      clr = ($urandom_range(0, 99) < 8);
      r   = $urandom_range(0, 99);
      if (r < 22) ack_drv = m_req;
      else if (r == 99) ack_drv = ~ack_drv;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
